// File: rtl/ram_2d_window_seq.sv
`default_nettype none
// ============================================================================
// Module   : ram_2d_window_seq
// Brief    : Writes a HEIGHT x WIDTH raster frame into an external RAM, then
//            streams every KxK stride-1 window element by element. Defining
//            WIN_LAST_EN adds a win_last output that flags each window's last
//            element.
// Revision : 1.0 - initial release
// ============================================================================
module ram_2d_window_seq #(
    parameter int DWIDTH = 32,
    parameter int HEIGHT = 8,
    parameter int WIDTH  = 8,
    parameter int K      = 3
) (
    input  logic                                           clk,
    input  logic                                           rst_n,
    input  logic                                           start,
    output logic                                           busy,
    output logic                                           done,
    input  logic                                           in_valid,
    output logic                                           in_ready,
    input  logic [DWIDTH-1:0]                              in_data,
    output logic                                           out_valid,
    input  logic                                           out_ready,
    output logic [DWIDTH-1:0]                              out_data,
`ifdef WIN_LAST_EN
    output logic                                           win_last,
`endif
    output logic                                           ram_rw,
    output logic [((HEIGHT > 1) ? $clog2(HEIGHT) : 1)-1:0] ram_haddr,
    output logic [((WIDTH > 1) ? $clog2(WIDTH) : 1)-1:0]   ram_waddr,
    output logic [DWIDTH-1:0]                              ram_datain,
    input  logic [DWIDTH-1:0]                              ram_dataout
);

    localparam int c_HAW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int c_WAW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [c_HAW-1:0] c_H_MAX  = c_HAW'(HEIGHT - 1);
    localparam logic [c_WAW-1:0] c_W_MAX  = c_WAW'(WIDTH - 1);
    localparam logic [c_HAW-1:0] c_OY_MAX = c_HAW'(HEIGHT - K);
    localparam logic [c_WAW-1:0] c_OX_MAX = c_WAW'(WIDTH - K);
    localparam logic [c_HAW-1:0] c_KY_MAX = c_HAW'(K - 1);
    localparam logic [c_WAW-1:0] c_KX_MAX = c_WAW'(K - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        RD_CAP = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic [c_HAW-1:0]  r_h;
    logic [c_WAW-1:0]  r_w;
    logic [c_HAW-1:0]  r_oy;
    logic [c_HAW-1:0]  r_ky;
    logic [c_WAW-1:0]  r_ox;
    logic [c_WAW-1:0]  r_kx;
    logic [c_HAW-1:0]  w_oy_n;
    logic [c_HAW-1:0]  w_ky_n;
    logic [c_WAW-1:0]  w_ox_n;
    logic [c_WAW-1:0]  w_kx_n;
    logic              r_prime;
    logic              r_done;
    logic [DWIDTH-1:0] r_out_data;
    logic              w_wr;
    logic              w_accept;
    logic              w_last_px;
    logic              w_last_elem;

    assign w_last_px   = (r_h == c_H_MAX) && (r_w == c_W_MAX);
    assign w_last_elem = (r_oy == c_OY_MAX) && (r_ox == c_OX_MAX) &&
                         (r_ky == c_KY_MAX) && (r_kx == c_KX_MAX);

    assign done     = r_done;
    assign out_data = r_out_data;

`ifdef WIN_LAST_EN
    assign win_last = out_valid && (r_ky == c_KY_MAX) && (r_kx == c_KX_MAX);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = (r_state != IDLE);
        in_ready    = (r_state == LOAD);
        out_valid   = (r_state == OUT);
        w_wr        = (r_state == LOAD) && in_valid;
        w_accept    = (r_state == OUT) && out_ready;
        case (r_state)
            IDLE:    if (start) w_state_nxt = LOAD;
            LOAD:    if (w_wr && w_last_px) w_state_nxt = RD_CAP;
            // The first RD_CAP cycle after LOAD only issues the (0,0) read.
            RD_CAP:  if (!r_prime) w_state_nxt = OUT;
            OUT:     if (w_accept) w_state_nxt = w_last_elem ? IDLE : RD_CAP;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Scan position that follows the current one (kx fastest, oy slowest).
    always_comb begin
        w_oy_n = r_oy;
        w_ox_n = r_ox;
        w_ky_n = r_ky;
        w_kx_n = r_kx;
        if (r_kx != c_KX_MAX) begin
            w_kx_n = r_kx + c_WAW'(1);
        end else begin
            w_kx_n = '0;
            if (r_ky != c_KY_MAX) begin
                w_ky_n = r_ky + c_HAW'(1);
            end else begin
                w_ky_n = '0;
                if (r_ox != c_OX_MAX) begin
                    w_ox_n = r_ox + c_WAW'(1);
                end else begin
                    w_ox_n = '0;
                    w_oy_n = (r_oy == c_OY_MAX) ? '0 : r_oy + c_HAW'(1);
                end
            end
        end
    end

    always_comb begin
        ram_rw     = !w_wr;
        ram_datain = '0;
        ram_haddr  = r_oy + r_ky;
        ram_waddr  = r_ox + r_kx;
        if (w_wr) begin
            ram_datain = in_data;
            ram_haddr  = r_h;
            ram_waddr  = r_w;
        end else if (w_accept) begin
            ram_haddr = w_oy_n + w_ky_n;
            ram_waddr = w_ox_n + w_kx_n;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_h        <= '0;
            r_w        <= '0;
            r_oy       <= '0;
            r_ox       <= '0;
            r_ky       <= '0;
            r_kx       <= '0;
            r_prime    <= 1'b0;
            r_done     <= 1'b0;
            r_out_data <= '0;
        end else begin
            r_done <= w_accept && w_last_elem;

            if ((r_state == IDLE) && start) begin
                r_h  <= '0;
                r_w  <= '0;
                r_oy <= '0;
                r_ox <= '0;
                r_ky <= '0;
                r_kx <= '0;
            end

            if (w_wr) begin
                if (r_w == c_W_MAX) begin
                    r_w <= '0;
                    r_h <= (r_h == c_H_MAX) ? '0 : r_h + c_HAW'(1);
                end else begin
                    r_w <= r_w + c_WAW'(1);
                end
            end

            if (w_wr && w_last_px) begin
                r_prime <= 1'b1;
            end else if (r_state == RD_CAP) begin
                r_prime <= 1'b0;
            end

            if ((r_state == RD_CAP) && !r_prime) begin
                r_out_data <= ram_dataout;
            end

            if (w_accept) begin
                r_oy <= w_oy_n;
                r_ox <= w_ox_n;
                r_ky <= w_ky_n;
                r_kx <= w_kx_n;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ram_2d_window_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_2d_window_seq
// Brief    : Self-checking bench for ram_2d_window_seq with a RAM model and a
//            frame-level reference of the expected window stream.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_2d_window_seq;

    localparam int DWIDTH = 32;
    localparam int HEIGHT = 8;
    localparam int WIDTH  = 8;
    localparam int K      = 3;
    localparam int HAW    = $clog2(HEIGHT);
    localparam int WAW    = $clog2(WIDTH);
    localparam int NPIX   = HEIGHT * WIDTH;
    localparam int NOUT   = (HEIGHT - K + 1) * (WIDTH - K + 1) * K * K;
    localparam int PH_IDLE = 0;
    localparam int PH_LOAD = 1;
    localparam int PH_SCAN = 2;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              busy;
    logic              done;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DWIDTH-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DWIDTH-1:0] out_data;
`ifdef WIN_LAST_EN
    logic              win_last;
`endif
    logic              ram_rw;
    logic [HAW-1:0]    ram_haddr;
    logic [WAW-1:0]    ram_waddr;
    logic [DWIDTH-1:0] ram_datain;
    logic [DWIDTH-1:0] ram_dataout = '0;
    logic [DWIDTH-1:0] mem [HEIGHT][WIDTH];

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    int phase = PH_IDLE;
    int ph0 = PH_IDLE;
    int ld_cnt = 0;
    int idx = 0;
    int wait_cyc = 0;
    int done_cnt = 0;
    bit exp_done = 1'b0;
    bit exp_ov;
    logic [DWIDTH-1:0] pix [NPIX];
    logic [DWIDTH-1:0] exp_q [$];
    int first9 [9] = '{0, 1, 2, 8, 9, 10, 16, 17, 18};
    int last9  [9] = '{45, 46, 47, 53, 54, 55, 61, 62, 63};

    ram_2d_window_seq #(
        .DWIDTH(DWIDTH), .HEIGHT(HEIGHT), .WIDTH(WIDTH), .K(K)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
`ifdef WIN_LAST_EN
        .win_last   (win_last),
`endif
        .ram_rw     (ram_rw),
        .ram_haddr  (ram_haddr),
        .ram_waddr  (ram_waddr),
        .ram_datain (ram_datain),
        .ram_dataout(ram_dataout)
    );

    always #5 clk = ~clk;

    // External RAM: write on ram_rw=0, read data registered one cycle later.
    always @(posedge clk) begin
        if (!ram_rw) mem[ram_haddr][ram_waddr] <= ram_datain;
        ram_dataout <= mem[ram_haddr][ram_waddr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected window stream straight from the scan-order definition.
    task automatic build_expected();
        exp_q.delete();
        for (int oy = 0; oy <= HEIGHT - K; oy++)
            for (int ox = 0; ox <= WIDTH - K; ox++)
                for (int ky = 0; ky < K; ky++)
                    for (int kx = 0; kx < K; kx++)
                        exp_q.push_back(pix[(oy + ky) * WIDTH + ox + kx]);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_in_ready", in_ready, 0);
            chk("rst_out_valid", out_valid, 0);
            chk("rst_out_data", out_data, 0);
            chk("rst_ram_rw", ram_rw, 1);
            chk("rst_haddr", ram_haddr, 0);
            chk("rst_waddr", ram_waddr, 0);
            chk("rst_datain", ram_datain, 0);
`ifdef WIN_LAST_EN
            chk("rst_win_last", win_last, 0);
`endif
            phase = PH_IDLE; ld_cnt = 0; idx = 0; wait_cyc = 0; exp_done = 1'b0;
        end else begin
            ph0 = phase;
            chk("done", done, exp_done);
            if (done) done_cnt++;
            exp_done = 1'b0;
            chk("busy", busy, ph0 != PH_IDLE);
            chk("in_ready", in_ready, ph0 == PH_LOAD);

            exp_ov = (ph0 == PH_SCAN) && (wait_cyc == 0);
            chk("out_valid", out_valid, exp_ov);
`ifdef WIN_LAST_EN
            chk("win_last", win_last, exp_ov && ((idx % (K * K)) == K * K - 1));
`endif
            if (exp_ov) begin
                chk("out_data", out_data, exp_q[idx]);
                if (out_ready) begin
                    idx++;
                    if (idx == NOUT) begin
                        phase = PH_IDLE;
                        exp_done = 1'b1;
                    end else begin
                        wait_cyc = 1;
                    end
                end
            end else if (ph0 == PH_SCAN) begin
                wait_cyc--;
            end

            if (ph0 == PH_LOAD && in_valid) begin
                chk("wr_ram_rw", ram_rw, 0);
                chk("wr_haddr", ram_haddr, ld_cnt / WIDTH);
                chk("wr_waddr", ram_waddr, ld_cnt % WIDTH);
                chk("wr_datain", ram_datain, in_data);
                pix[ld_cnt] = in_data;
                ld_cnt++;
                if (ld_cnt == NPIX) begin
                    build_expected();
                    phase = PH_SCAN;
                    wait_cyc = 2;
                    idx = 0;
                end
            end else begin
                chk("ram_rw", ram_rw, 1);
            end

            if (ph0 == PH_IDLE && start) begin
                phase = PH_LOAD;
                ld_cnt = 0;
            end
        end
    end

    task automatic run_frame(input bit seq_data, input bit gaps, input bit bp,
                             input bit rstart, input int abort_at);
        int c;
        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        c = 0;
        while ((phase != PH_IDLE || exp_done) && c < 6000) begin
            if (abort_at >= 0 && phase == PH_SCAN && idx >= abort_at) begin
                rst_n = 1'b0;
                #1;
                chk("abort_busy", busy, 0);
                chk("abort_out_valid", out_valid, 0);
                chk("abort_in_ready", in_ready, 0);
                chk("abort_ram_rw", ram_rw, 1);
                repeat (2) @(posedge clk);
                #1;
                rst_n = 1'b1; in_valid = 1'b0; start = 1'b0;
                return;
            end
            in_valid  = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            in_data   = seq_data ? DWIDTH'(ld_cnt) : DWIDTH'($urandom());
            out_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            start     = (rstart && phase != PH_IDLE) ? ($urandom_range(0, 4) == 0) : 1'b0;
            @(posedge clk); #1;
            c++;
        end
        chk("frame_timeout", c < 6000, 1);
        in_valid = 1'b0; start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Pixels 0..63, no gaps, no backpressure
        run_frame(1'b1, 1'b0, 1'b0, 1'b0, -1);
        chk("exp_count", exp_q.size(), NOUT);
        chk("exp_count_lit", exp_q.size(), 324);
        for (int i = 0; i < 9; i++) begin
            chk("first9", exp_q[i], first9[i]);
            chk("last9", exp_q[exp_q.size() - 9 + i], last9[i]);
        end
        chk("done_cnt_a", done_cnt, 1);

        // Random data, input gaps, output backpressure, stray start pulses
        run_frame(1'b0, 1'b1, 1'b1, 1'b1, -1);
        chk("done_cnt_b", done_cnt, 2);

        // Reset after element 100, then reload and rescan
        run_frame(1'b1, 1'b1, 1'b0, 1'b0, 100);
        chk("done_cnt_abort", done_cnt, 2);
        run_frame(1'b0, 1'b1, 1'b1, 1'b0, -1);
        chk("done_cnt_c", done_cnt, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
